ones_pattern_generator: RTL
===========================

ONES_PATTERN_GENERATOR -- requirements
Module: ones_pattern_generator

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, named as below.
REQ-002 Parameter: GAP, default 1, idle cycles (0..15) inserted between repeated passes.
REQ-003 clk  input  1  rising-edge clock; all state changes on this edge only.
REQ-004 reset  input  1  synchronous active-low reset; sampled on clk rising edge.
REQ-005 start  input  1  request to begin transmission; sampled only in IDLE.
REQ-006 pattern  input  8  bits to send, LSB first; captured on start acceptance.
REQ-007 len  input  4  bits per pass; 1..8 used as-is; 0 and 9..15 SHALL be treated as 8.
REQ-008 reps  input  4  number of passes; 0 SHALL be treated as 1.
REQ-009 aout  output  1  serial data bit; registered.
REQ-010 aval  output  1  high when aout carries a pattern bit; registered.
REQ-011 busy  output  1  high from the cycle after acceptance until the last bit has been sent.
REQ-012 done  output  1  single-cycle pulse marking completion.
REQ-013 ones_count  output  4  running count of transmitted 1 bits, modulo 16.

Function
REQ-014 FSM states SHALL be IDLE, SHIFT, GAP and DONE; unused encodings SHALL return to IDLE on the next edge.
REQ-015 IDLE: aout=0, aval=0, busy=0, done=0; start=1 at edge k SHALL capture pattern, effective len and effective reps into internal registers, then enter SHIFT.
REQ-016 Latency: first bit (pattern[0]) SHALL appear on aout with aval=1 in the cycle following edge k; bit i SHALL appear in cycle k+1+i.
REQ-017 SHIFT: one bit per cycle, aval=1, busy=1; source SHALL be the captured copy, so changes to pattern, len or reps mid-run have no effect.
REQ-018 After the last bit of a pass, with passes remaining: GAP>0 -> GAP state for exactly GAP cycles with aout=0, aval=0, busy=1; GAP=0 -> next pass starts in the very next cycle with no bubble.
REQ-019 After the last bit of the final pass -> DONE for one cycle: done=1, busy=0, aval=0, aout=0; then IDLE.
REQ-020 start SHALL be ignored in SHIFT, GAP and DONE; earliest re-acceptance is the first IDLE cycle after DONE.
REQ-021 ones_count SHALL increment by 1 on each cycle with aval=1 and aout=1, wrapping 15->0; it SHALL NOT clear on start.
REQ-022 Total cycles with busy=1 SHALL be reps_eff*len_eff + (reps_eff-1)*GAP.

Reset
REQ-023 reset=0 at any clock edge SHALL force IDLE, aout=0, aval=0, busy=0, done=0 and ones_count=0 on that edge; this includes reset during SHIFT or GAP, where the run is discarded without a done pulse.
REQ-024 reset=0 SHALL take priority over start when both are asserted on the same edge.
REQ-025 While reset=0 is held, all outputs SHALL remain at their reset values.

Verification
REQ-026 pattern=8'hB2, len=8, reps=1: aout=0,1,0,0,1,1,0,1 on 8 consecutive cycles with aval=1 -> done pulse on the 9th cycle, ones_count=4.
REQ-027 pattern=8'h05, len=3, reps=3, GAP=1: aout/aval sequence is 1,0,1,gap,1,0,1,gap,1,0,1, with busy high for 11 cycles -> done, then ones_count=6.
REQ-028 len=0, pattern=8'h80, reps=0: 8 bits are sent, with only the final bit =1 -> single pass, ones_count=1.
REQ-029 Second start pulse plus pattern change mid-run: the output stream is unchanged and no second run begins before IDLE.
REQ-030 reset=0 in the 3rd bit of a SHIFT: on the next edge all outputs are 0 and ones_count=0; no done pulse follows.
REQ-031 pattern=8'hFF, len=8, reps=2, GAP=0: 16 contiguous aval cycles -> ones_count wraps to 0.

Source files
------------

// File: rtl/ones_pattern_generator_if.sv
// Request/stream bundle for the ones pattern generator: run request in, serial bits and status out.
// master drives the request side; slave is the generator.
interface ones_pattern_generator_if;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [3:0] reps;
    logic       aout;
    logic       aval;
    logic       busy;
    logic       done;
    logic [3:0] ones_count;

    modport master (
        output start, pattern, len, reps,
        input  aout, aval, busy, done, ones_count
    );

    modport slave (
        input  start, pattern, len, reps,
        output aout, aval, busy, done, ones_count
    );
endinterface

// File: rtl/ones_pattern_generator.sv
// Serialises a captured 8-bit pattern LSB first, reps passes of len bits with GAP idle cycles between passes.
// First bit one cycle after start is accepted; no backpressure, start is ignored until the block is back in IDLE.
module ones_pattern_generator #(
    parameter int GAP = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    ones_pattern_generator_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    state_t     state;
    logic [7:0] pat_q;
    logic [7:0] sh_q;
    logic [3:0] len_q;
    logic [3:0] reps_q;
    logic [3:0] bit_cnt;
    logic [3:0] gap_cnt;
    logic       aout_q;
    logic       aval_q;
    logic       busy_q;
    logic       done_q;
    logic [3:0] ones_q;
    logic [3:0] len_eff;
    logic [3:0] reps_eff;

    always_comb begin
        len_eff  = ((bus.len == 4'd0) || (bus.len > 4'd8)) ? 4'd8 : bus.len;
        reps_eff = (bus.reps == 4'd0) ? 4'd1 : bus.reps;
    end

    assign bus.aout       = aout_q;
    assign bus.aval       = aval_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.ones_count = ones_q;

    // Outputs are registered alongside the state, so they always describe the cycle the state names.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            pat_q   <= 8'd0;
            sh_q    <= 8'd0;
            len_q   <= 4'd8;
            reps_q  <= 4'd1;
            bit_cnt <= 4'd0;
            gap_cnt <= 4'd0;
            aout_q  <= 1'b0;
            aval_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ones_q  <= 4'd0;
        end else begin
            if (aval_q && aout_q) begin
                ones_q <= ones_q + 4'd1;
            end

            case (state)
                S_IDLE: begin
                    aout_q <= 1'b0;
                    aval_q <= 1'b0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (bus.start) begin
                        pat_q   <= bus.pattern;
                        len_q   <= len_eff;
                        reps_q  <= reps_eff;
                        sh_q    <= {1'b0, bus.pattern[7:1]};
                        bit_cnt <= 4'd1;
                        aout_q  <= bus.pattern[0];
                        aval_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        state   <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    if (bit_cnt < len_q) begin
                        aout_q  <= sh_q[0];
                        sh_q    <= {1'b0, sh_q[7:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                    end else if (reps_q > 4'd1) begin
                        reps_q <= reps_q - 4'd1;
                        if (GAP > 0) begin
                            gap_cnt <= GAP_LAST;
                            aout_q  <= 1'b0;
                            aval_q  <= 1'b0;
                            state   <= S_GAP;
                        end else begin
                            // Back-to-back pass: reload from the captured copy with no bubble.
                            aout_q  <= pat_q[0];
                            sh_q    <= {1'b0, pat_q[7:1]};
                            bit_cnt <= 4'd1;
                        end
                    end else begin
                        aout_q <= 1'b0;
                        aval_q <= 1'b0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end
                end

                S_GAP: begin
                    if (gap_cnt == 4'd0) begin
                        aout_q  <= pat_q[0];
                        aval_q  <= 1'b1;
                        sh_q    <= {1'b0, pat_q[7:1]};
                        bit_cnt <= 4'd1;
                        state   <= S_SHIFT;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end

                S_DONE: begin
                    done_q <= 1'b0;
                    state  <= S_IDLE;
                end

                default: begin
                    aout_q <= 1'b0;
                    aval_q <= 1'b0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule
